// File: rtl/conv1d_sequencer.sv
// Job sequencer for a conv1d datapath: configures it once per job, then loads weights,
// writes per-filter parameters, runs and polls the datapath, and streams out one result per filter.
module conv1d_sequencer #(
  parameter int NUM_FILTERS_W = 8,
  parameter int POLL_TIMEOUT  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_FILTERS_W-1:0] num_filters,
  input  logic [31:0]              input_depth,
  input  logic [31:0]              start_x,
  input  logic [31:0]              input_offset,
  input  logic [31:0]              act_min,
  input  logic [31:0]              act_max,
  input  logic [31:0]              out_offset,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [NUM_FILTERS_W-1:0] filt_idx,
  output logic                     wload_req,
  input  logic                     wload_ack,
  output logic                     param_req,
  input  logic                     param_ack,
  input  logic [31:0]              bias,
  input  logic [31:0]              mult,
  input  logic [31:0]              shift,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [6:0]               host_cmd,
  input  logic [31:0]              host_inp0,
  input  logic [31:0]              host_inp1,
  output logic                     cfu_en,
  output logic [6:0]               cfu_cmd,
  output logic [31:0]              cfu_inp0,
  output logic [31:0]              cfu_inp1,
  input  logic [31:0]              cfu_ret,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [NUM_FILTERS_W-1:0] res_idx
);

  // IDLE wait start | CFG job config cmds | WLOAD host loads weights | PARAM fetch filter params
  // PWRITE write params | START kick datapath | POLL wait done | READ fetch result | OUT stream | DONE pulse
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CFG    = 4'd1;
  localparam logic [3:0] S_WLOAD  = 4'd2;
  localparam logic [3:0] S_PARAM  = 4'd3;
  localparam logic [3:0] S_PWRITE = 4'd4;
  localparam logic [3:0] S_START  = 4'd5;
  localparam logic [3:0] S_POLL   = 4'd6;
  localparam logic [3:0] S_READ   = 4'd7;
  localparam logic [3:0] S_OUT    = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam int PC_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [NUM_FILTERS_W-1:0] ONE_F = NUM_FILTERS_W'(1);

  logic [3:0]               r_state;
  logic [2:0]               r_step;
  logic [PC_W-1:0]          r_poll_cnt;
  logic [NUM_FILTERS_W-1:0] r_filt_idx;
  logic [NUM_FILTERS_W-1:0] r_num_filters;
  logic [31:0]              r_bias;
  logic [31:0]              r_mult;
  logic [31:0]              r_shift;
  logic [31:0]              r_res_data;
  logic                     r_error;
  logic                     w_host_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_step        <= '0;
      r_poll_cnt    <= '0;
      r_filt_idx    <= '0;
      r_num_filters <= '0;
      r_bias        <= '0;
      r_mult        <= '0;
      r_shift       <= '0;
      r_res_data    <= '0;
      r_error       <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_error       <= 1'b0;
          r_filt_idx    <= '0;
          r_num_filters <= num_filters;
          r_step        <= '0;
          r_state       <= (num_filters == '0) ? S_DONE : S_CFG;
        end
        S_CFG: begin
          if (r_step == 3'd5) begin
            r_step  <= '0;
            r_state <= S_WLOAD;
          end else r_step <= r_step + 3'd1;
        end
        S_WLOAD: if (wload_ack) r_state <= S_PARAM;
        S_PARAM: if (param_ack) begin
          r_bias  <= bias;
          r_mult  <= mult;
          r_shift <= shift;
          r_step  <= '0;
          r_state <= S_PWRITE;
        end
        S_PWRITE: begin
          if (r_step == 3'd2) begin
            r_step  <= '0;
            r_state <= S_START;
          end else r_step <= r_step + 3'd1;
        end
        S_START: begin
          r_poll_cnt <= '0;
          r_state    <= S_POLL;
        end
        // cfu_ret in the first poll cycle answers an older command, so it is ignored
        S_POLL: begin
          if (r_poll_cnt != '0 && cfu_ret[0]) begin
            r_step  <= '0;
            r_state <= S_READ;
          end else if (r_poll_cnt == PC_W'(POLL_TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else r_poll_cnt <= r_poll_cnt + PC_W'(1);
        end
        S_READ: begin
          if (r_step == 3'd0) r_step <= 3'd1;
          else begin
            r_res_data <= cfu_ret;
            r_step     <= '0;
            r_state    <= S_OUT;
          end
        end
        S_OUT: if (res_ready) begin
          if (r_filt_idx == r_num_filters - ONE_F) r_state <= S_DONE;
          else begin
            r_filt_idx <= r_filt_idx + ONE_F;
            r_state    <= S_WLOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host_ready  = (r_state == S_IDLE || r_state == S_WLOAD) && !reset;
  assign w_host_fire = host_valid && host_ready;

  always_comb begin
    cfu_en   = 1'b0;
    cfu_cmd  = '0;
    cfu_inp0 = '0;
    cfu_inp1 = '0;
    case (r_state)
      S_CFG: begin
        cfu_en = 1'b1;
        case (r_step)
          3'd0:    begin cfu_cmd = 7'd3;  cfu_inp1 = input_offset; end
          3'd1:    begin cfu_cmd = 7'd5;  cfu_inp1 = input_depth;  end
          3'd2:    begin cfu_cmd = 7'd8;  cfu_inp1 = start_x;      end
          3'd3:    begin cfu_cmd = 7'd15; cfu_inp1 = act_min;      end
          3'd4:    begin cfu_cmd = 7'd16; cfu_inp1 = act_max;      end
          default: begin cfu_cmd = 7'd17; cfu_inp1 = out_offset;   end
        endcase
      end
      S_PWRITE: begin
        cfu_en = 1'b1;
        case (r_step)
          3'd0:    begin cfu_cmd = 7'd12; cfu_inp1 = r_bias;  end
          3'd1:    begin cfu_cmd = 7'd13; cfu_inp1 = r_mult;  end
          default: begin cfu_cmd = 7'd14; cfu_inp1 = r_shift; end
        endcase
      end
      S_START: begin cfu_en = 1'b1; cfu_cmd = 7'd6; end
      S_POLL:  begin cfu_en = 1'b1; cfu_cmd = 7'd9; end
      S_READ: if (r_step == 3'd0) begin
        cfu_en  = 1'b1;
        cfu_cmd = 7'd7;
      end
      default: if (w_host_fire) begin
        cfu_en   = 1'b1;
        cfu_cmd  = host_cmd;
        cfu_inp0 = host_inp0;
        cfu_inp1 = host_inp1;
      end
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign error     = r_error;
  assign filt_idx  = r_filt_idx;
  assign wload_req = (r_state == S_WLOAD);
  assign param_req = (r_state == S_PARAM);
  assign res_valid = (r_state == S_OUT);
  assign res_data  = r_res_data;
  assign res_idx   = r_filt_idx;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Directed bench for conv1d_sequencer with a small behavioural datapath model
// (done 4 cycles after cmd 6, result = last bias ^ 5A5A0000).
module tb_conv1d_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [7:0]  num_filters;
  logic [31:0] input_depth, start_x, input_offset, act_min, act_max, out_offset;
  logic        busy, done, error;
  logic [7:0]  filt_idx;
  logic        wload_req, wload_ack, param_req, param_ack;
  logic [31:0] bias, mult, shift;
  logic        host_valid, host_ready;
  logic [6:0]  host_cmd;
  logic [31:0] host_inp0, host_inp1;
  logic        cfu_en;
  logic [6:0]  cfu_cmd;
  logic [31:0] cfu_inp0, cfu_inp1, cfu_ret;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [7:0]  res_idx;

  logic        ack_en, rdy_en, dp_hang;
  logic [31:0] dp_ret, dp_bias;
  int          dp_cnt;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [6:0]  cmd_log[$];
  logic [31:0] inp0_log[$];
  logic [31:0] inp1_log[$];
  logic [31:0] rdata_log[$];
  logic [7:0]  ridx_log[$];

  always #5 clk = ~clk;

  conv1d_sequencer #(.NUM_FILTERS_W(8), .POLL_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_filters(num_filters),
    .input_depth(input_depth), .start_x(start_x), .input_offset(input_offset),
    .act_min(act_min), .act_max(act_max), .out_offset(out_offset),
    .busy(busy), .done(done), .error(error), .filt_idx(filt_idx),
    .wload_req(wload_req), .wload_ack(wload_ack), .param_req(param_req), .param_ack(param_ack),
    .bias(bias), .mult(mult), .shift(shift),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_inp0(host_inp0), .host_inp1(host_inp1),
    .cfu_en(cfu_en), .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0), .cfu_inp1(cfu_inp1), .cfu_ret(cfu_ret),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
  );

  assign wload_ack = ack_en && wload_req;
  assign param_ack = ack_en && param_req;
  assign res_ready = rdy_en;
  assign bias      = 32'h0000_1000 + {24'h0, filt_idx};
  assign mult      = 32'h0000_0777;
  assign shift     = 32'h0000_0005;
  assign cfu_ret   = dp_ret;

  // datapath model: cfu_ret answers the command of the previous cycle
  always @(posedge clk) begin
    if (cfu_en && cfu_cmd == 7'd6) dp_cnt <= 4;
    else if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
    if (cfu_en && cfu_cmd == 7'd12) dp_bias <= cfu_inp1;
    if (cfu_en && cfu_cmd == 7'd9) dp_ret <= {31'h0, (dp_cnt == 0) && !dp_hang};
    else if (cfu_en && cfu_cmd == 7'd7) dp_ret <= dp_bias ^ 32'h5A5A_0000;
  end

  always @(posedge clk) begin
    if (cfu_en) begin
      cmd_log.push_back(cfu_cmd);
      inp0_log.push_back(cfu_inp0);
      inp1_log.push_back(cfu_inp1);
    end
    if (res_valid && res_ready) begin
      rdata_log.push_back(res_data);
      ridx_log.push_back(res_idx);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic int count_cmd(input logic [6:0] c);
    int n = 0;
    foreach (cmd_log[i]) if (cmd_log[i] == c) n++;
    return n;
  endfunction

  task automatic clear_logs();
    cmd_log.delete(); inp0_log.delete(); inp1_log.delete();
    rdata_log.delete(); ridx_log.delete();
  endtask

  task automatic start_job(input logic [7:0] nf);
    num_filters = nf;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_timeout: busy=%0b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, error, wload_req, param_req, res_valid, cfu_en} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, error, wload_req, param_req, res_valid, cfu_en});
    end
    checks++;
    if (filt_idx !== 8'd0 || res_idx !== 8'd0 || res_data !== 32'd0 || cfu_cmd !== 7'd0) begin
      failures++;
      $display("FAIL reset_data: filt_idx=%0d res_idx=%0d res_data=%h cfu_cmd=%0d expected all 0",
               filt_idx, res_idx, res_data, cfu_cmd);
    end
    checks++;
    if (host_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_host_ready: got %0b expected 1", host_ready);
    end
  endtask

  task automatic test_main_job();
    logic [6:0]  exp_cmd[9];
    logic [31:0] exp_val[9];
    int d0;
    exp_cmd = '{7'd3, 7'd5, 7'd8, 7'd15, 7'd16, 7'd17, 7'd12, 7'd13, 7'd14};
    exp_val = '{32'h11, 32'd2, 32'd0, 32'hFFFF_FF80, 32'h7F, 32'h22, 32'h1000, 32'h777, 32'h5};
    clear_logs();
    d0 = done_cnt;
    start_job(8'd2);
    wait_idle(200, "main");
    @(negedge clk);
    checks++;
    if (cmd_log.size() < 9) begin
      failures++;
      $display("FAIL main_cmd_count: got %0d commands expected at least 9", cmd_log.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cmd_log[i] !== exp_cmd[i] || inp1_log[i] !== exp_val[i] || inp0_log[i] !== 32'd0) begin
          failures++;
          $display("FAIL main_seq[%0d]: cmd=%0d inp1=%h inp0=%h expected cmd=%0d inp1=%h inp0=0",
                   i, cmd_log[i], inp1_log[i], inp0_log[i], exp_cmd[i], exp_val[i]);
        end
      end
    end
    checks++;
    if (count_cmd(7'd3) != 1 || count_cmd(7'd6) != 2 || count_cmd(7'd7) != 2 || count_cmd(7'd12) != 2) begin
      failures++;
      $display("FAIL main_cmd_totals: cmd3=%0d cmd6=%0d cmd7=%0d cmd12=%0d expected 1 2 2 2",
               count_cmd(7'd3), count_cmd(7'd6), count_cmd(7'd7), count_cmd(7'd12));
    end
    checks++;
    if (rdata_log.size() != 2) begin
      failures++;
      $display("FAIL main_results: got %0d results expected 2", rdata_log.size());
    end else begin
      checks++;
      if (ridx_log[0] !== 8'd0 || rdata_log[0] !== 32'h5A5A_1000) begin
        failures++;
        $display("FAIL main_res0: idx=%0d data=%h expected idx=0 data=5a5a1000", ridx_log[0], rdata_log[0]);
      end
      checks++;
      if (ridx_log[1] !== 8'd1 || rdata_log[1] !== 32'h5A5A_1001) begin
        failures++;
        $display("FAIL main_res1: idx=%0d data=%h expected idx=1 data=5a5a1001", ridx_log[1], rdata_log[1]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || error !== 1'b0) begin
      failures++;
      $display("FAIL main_done: done pulses=%0d error=%0b expected 1 and 0", done_cnt - d0, error);
    end
  endtask

  task automatic test_zero_filters();
    int d0;
    clear_logs();
    d0 = done_cnt;
    start_job(8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL zero_done: done pulses=%0d expected 1", done_cnt - d0);
    end
    checks++;
    if (cmd_log.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_cfu: commands=%0d busy=%0b expected 0 and 0", cmd_log.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int d0;
    clear_logs();
    d0 = done_cnt;
    rdy_en = 1'b0;
    start_job(8'd2);
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_reach_out: res_valid=%0b expected 1", res_valid);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'h5A5A_1000 || res_idx !== 8'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h idx=%0d expected 1 5a5a1000 0",
                 i, res_valid, res_data, res_idx);
      end
      @(negedge clk);
    end
    checks++;
    if (count_cmd(7'd6) != 1) begin
      failures++;
      $display("FAIL bp_no_cmd6: cmd6 count=%0d expected 1", count_cmd(7'd6));
    end
    rdy_en = 1'b1;
    wait_idle(200, "bp");
    @(negedge clk);
    checks++;
    if (count_cmd(7'd6) != 2 || rdata_log.size() != 2 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL bp_finish: cmd6=%0d results=%0d done=%0d expected 2 2 1",
               count_cmd(7'd6), rdata_log.size(), done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int d0;
    clear_logs();
    d0 = done_cnt;
    dp_hang = 1'b1;
    start_job(8'd1);
    wait_idle(200, "timeout");
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || done_cnt - d0 != 0) begin
      failures++;
      $display("FAIL timeout_state: error=%0b busy=%0b done=%0d expected 1 0 0", error, busy, done_cnt - d0);
    end
    checks++;
    if (count_cmd(7'd9) != 16 || count_cmd(7'd7) != 0) begin
      failures++;
      $display("FAIL timeout_polls: cmd9=%0d cmd7=%0d expected 16 0", count_cmd(7'd9), count_cmd(7'd7));
    end
    dp_hang = 1'b0;
    start_job(8'd1);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear: error=%0b busy=%0b expected 0 1", error, busy);
    end
    wait_idle(200, "timeout_rerun");
  endtask

  task automatic test_host_stall();
    int stalls = 0;
    int d0;
    clear_logs();
    d0 = done_cnt;
    ack_en = 1'b0;
    start_job(8'd1);
    host_valid = 1'b1;
    host_cmd   = 7'h55;
    host_inp0  = 32'hAAAA_0001;
    host_inp1  = 32'hBBBB_0002;
    while (!host_ready && stalls < 50) begin stalls++; @(negedge clk); end
    ack_en = 1'b1;
    checks++;
    if (stalls != 6 || wload_req !== 1'b1) begin
      failures++;
      $display("FAIL host_stall_cycles: stalled=%0d wload_req=%0b expected 6 1", stalls, wload_req);
    end
    checks++;
    if (cfu_en !== 1'b1 || cfu_cmd !== 7'h55 || cfu_inp0 !== 32'hAAAA_0001 || cfu_inp1 !== 32'hBBBB_0002) begin
      failures++;
      $display("FAIL host_forward: en=%0b cmd=%h inp0=%h inp1=%h expected 1 55 aaaa0001 bbbb0002",
               cfu_en, cfu_cmd, cfu_inp0, cfu_inp1);
    end
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if (param_req !== 1'b1) begin
      failures++;
      $display("FAIL host_with_ack: param_req=%0b expected 1", param_req);
    end
    wait_idle(200, "host");
    @(negedge clk);
    checks++;
    if (count_cmd(7'h55) != 1 || done_cnt - d0 != 1 || rdata_log.size() != 1) begin
      failures++;
      $display("FAIL host_job: host cmds=%0d done=%0d results=%0d expected 1 1 1",
               count_cmd(7'h55), done_cnt - d0, rdata_log.size());
    end
  endtask

  task automatic test_cancel(input logic use_reset, input string name);
    int n = 0;
    int d0;
    clear_logs();
    d0 = done_cnt;
    start_job(8'd1);
    while (!(cfu_en && cfu_cmd == 7'd9) && n < 100) begin @(negedge clk); n++; end
    if (use_reset) reset = 1'b1; else abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfu_en !== 1'b0 || res_valid !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%0b cfu_en=%0b res_valid=%0b error=%0b expected 0 0 0 0",
               name, busy, cfu_en, res_valid, error);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 0) begin
      failures++;
      $display("FAIL %s_no_done: done=%0d expected 0", name, done_cnt - d0);
    end
    clear_logs();
    start_job(8'd1);
    wait_idle(200, name);
    @(negedge clk);
    checks++;
    if (rdata_log.size() != 1 || done_cnt - d0 != 1 || count_cmd(7'd3) != 1) begin
      failures++;
      $display("FAIL %s_rerun: results=%0d done=%0d cmd3=%0d expected 1 1 1",
               name, rdata_log.size(), done_cnt - d0, count_cmd(7'd3));
    end else begin
      checks++;
      if (rdata_log[0] !== 32'h5A5A_1000) begin
        failures++;
        $display("FAIL %s_rerun_data: got %h expected 5a5a1000", name, rdata_log[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_filters = 8'd0;
    input_offset = 32'h11; input_depth = 32'd2; start_x = 32'd0;
    act_min = 32'hFFFF_FF80; act_max = 32'h7F; out_offset = 32'h22;
    host_valid = 1'b0; host_cmd = 7'd0; host_inp0 = 32'd0; host_inp1 = 32'd0;
    ack_en = 1'b1; rdy_en = 1'b1; dp_hang = 1'b0;
    dp_ret = 32'd0; dp_bias = 32'd0; dp_cnt = 0;
    test_reset();
    test_main_job();
    test_zero_filters();
    test_backpressure();
    test_timeout();
    test_host_stall();
    test_cancel(1'b0, "abort");
    test_cancel(1'b1, "midreset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv1d_sequencer.md
CONV1D_SEQUENCER -- requirements
Module: conv1d_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_FILTERS_W, default 8, meaning the width of the filter count and filter index.
REQ-002 The module SHALL have parameter POLL_TIMEOUT, default 4096, meaning the maximum number of poll cycles per filter before an error is raised.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
REQ-004 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle job start, accepted only in IDLE
- abort  in  1  synchronous job cancel
- num_filters  in  NUM_FILTERS_W  number of output channels in the job
- input_depth, start_x, input_offset  in  32 each  job configuration
- act_min, act_max, out_offset  in  32 each  static quantisation parameters
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse when the job completes
- error  out  1  sticky poll timeout, cleared by start or reset
- filt_idx  out  NUM_FILTERS_W  index of the current filter
- wload_req  out  1, wload_ack  in  1  weight-load handshake
- param_req  out  1, param_ack  in  1  per-filter parameter handshake
- bias, mult, shift  in  32 each  per-filter parameters, valid while param_ack is high
- host_valid  in  1, host_ready  out  1, host_cmd  in  7, host_inp0  in  32, host_inp1  in  32  host passthrough to the datapath
- cfu_en  out  1, cfu_cmd  out  7, cfu_inp0  out  32, cfu_inp1  out  32, cfu_ret  in  32  port to the conv1d datapath
- res_valid  out  1, res_ready  in  1, res_data  out  32, res_idx  out  NUM_FILTERS_W  result stream

Function
REQ-005 The FSM SHALL use these states: IDLE, CFG, WLOAD, PARAM, PWRITE, START, POLL, READ, OUT, DONE.
REQ-006 On start in IDLE, the module SHALL clear error, set filt_idx to 0, and enter CFG; if num_filters is 0, it SHALL enter DONE instead.
REQ-007 CFG SHALL issue one command per cycle, in this order: cmd 3 (input_offset), 5 (input_depth), 8 (start_x), 15 (act_min), 16 (act_max), 17 (out_offset), with the value on cfu_inp1 and cfu_inp0 at 0; after the 6th cycle it SHALL enter WLOAD.
REQ-008 WLOAD SHALL hold wload_req high and SHALL enter PARAM in the cycle after wload_ack is sampled high.
REQ-009 PARAM SHALL hold param_req high; on param_ack it SHALL register bias, mult and shift and enter PWRITE.
REQ-010 PWRITE SHALL issue cmd 12, 13 and 14 on three consecutive cycles, then enter START.
REQ-011 START SHALL issue cmd 6 for one cycle, clear the poll counter, then enter POLL.
REQ-012 POLL SHALL issue cmd 9 every cycle.
REQ-013 Because cfu_ret is valid one cycle after the issuing cycle, cfu_ret SHALL be sampled from the second POLL cycle onward; when cfu_ret[0] is 1, the FSM SHALL enter READ.
REQ-014 If the poll count reaches POLL_TIMEOUT, the module SHALL set error, skip done, and return to IDLE.
REQ-015 READ SHALL issue cmd 7 for one cycle, capture cfu_ret into res_data in the following cycle, and enter OUT.
REQ-016 OUT SHALL hold res_valid, res_data and res_idx (equal to filt_idx) stable until res_ready is high.
REQ-017 On the handshake in OUT: if filt_idx equals num_filters-1, the FSM SHALL enter DONE; otherwise it SHALL increment filt_idx and enter WLOAD.
REQ-018 In WLOAD, the module SHALL reuse the CFG values and SHALL NOT repeat CFG.
REQ-019 DONE SHALL pulse done for one cycle, then enter IDLE.
REQ-020 cfu_en SHALL be high only on command-issuing cycles; at all other times cfu_cmd, cfu_inp0 and cfu_inp1 SHALL be 0.
REQ-021 host_ready SHALL be 1 only in IDLE and WLOAD.
REQ-022 When host_valid and host_ready are both high, host_cmd, host_inp0 and host_inp1 SHALL be forwarded with cfu_en=1 in the same cycle, combinationally.
REQ-023 Outside IDLE and WLOAD, host traffic SHALL be stalled and never dropped.
REQ-024 If wload_ack and a host write coincide in WLOAD, the host write SHALL still be forwarded that cycle.
REQ-025 The start input SHALL be ignored while busy.
REQ-026 abort in any state SHALL return the FSM to IDLE on the next cycle, with no done pulse, res_valid low and error unchanged; abort SHALL have priority over all other transitions except reset.
REQ-027 A filt_idx increment SHALL never wrap; num_filters=2^NUM_FILTERS_W-1 is the maximum job size.

Reset
REQ-028 Reset SHALL have priority over all other inputs.
REQ-029 Reset SHALL force the IDLE state and drive busy, done, error, wload_req, param_req, res_valid and cfu_en to 0, and filt_idx, res_data, res_idx and cfu_cmd to 0.
REQ-030 Reset mid-job SHALL behave like abort and also clear error.

Verification
REQ-031 Run a job with num_filters=2, input_depth=2, start_x=0, immediate acks and a datapath model reporting done 4 cycles after cmd 6 -> the CFG command sequence 3,5,8,15,16,17 appears, two results come out with res_idx 0 then 1, and a done pulse follows.
REQ-032 Start a job with num_filters=0 -> DONE is entered immediately, done pulses within 2 cycles, and cfu_en never goes high.
REQ-033 Hold res_ready low for 10 cycles in OUT -> res_data and res_idx stay stable and no new cmd 6 is issued until the handshake.
REQ-034 Hold cfu_ret[0] at 0 forever -> after POLL_TIMEOUT polls, error=1, busy=0 and done is never pulsed.
REQ-035 Send host_valid in CFG and then in WLOAD -> the host write is stalled in CFG and forwarded on its first WLOAD cycle with the exact cmd and data.
REQ-036 Assert abort, and separately assert reset, during POLL -> IDLE is reached next cycle, cfu_en=0, and a new start runs cleanly.
